// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t     : control FSM encoding (IDLE, RUN, DONE)
//   MUL_WIDTH   : default operand width
//   PROD_WIDTH  : product width, equal to the carry-select adder width
//   cnt_width() : width of a counter that must hold the values 0..n
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int MUL_WIDTH  = 8;
  localparam int PROD_WIDTH = 16;

  // Never returns less than 1, so SETTLE_CYCLES=0 still gets a legal vector.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int STEP_CNT_W = cnt_width(MUL_WIDTH);
  localparam int WAIT_CNT_W = cnt_width(1);

endpackage

// File: rtl/CarrySelectAdder_16bit_3_3_6_4.sv
// 16-bit carry-select adder, block partition 3/3/6/4 (LSB first).
// Block 0 ripples from i_cin. Every higher block precomputes its sum for
// carry-in 0 and 1, and the carry out of the block below selects one.
//   i_a, i_b : 16-bit addends
//   i_cin    : carry in
//   o_sum    : 16-bit sum
//   o_cout   : carry out of bit 15
module CarrySelectAdder_16bit_3_3_6_4 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [3:0] w_blk0;
  logic [3:0] w_blk1_c0, w_blk1_c1;
  logic [6:0] w_blk2_c0, w_blk2_c1;
  logic [4:0] w_blk3_c0, w_blk3_c1;
  logic       w_c3, w_c6, w_c12;

  assign w_blk0    = {1'b0, i_a[2:0]} + {1'b0, i_b[2:0]} + {3'b000, i_cin};

  assign w_blk1_c0 = {1'b0, i_a[5:3]} + {1'b0, i_b[5:3]};
  assign w_blk1_c1 = {1'b0, i_a[5:3]} + {1'b0, i_b[5:3]} + 4'd1;

  assign w_blk2_c0 = {1'b0, i_a[11:6]} + {1'b0, i_b[11:6]};
  assign w_blk2_c1 = {1'b0, i_a[11:6]} + {1'b0, i_b[11:6]} + 7'd1;

  assign w_blk3_c0 = {1'b0, i_a[15:12]} + {1'b0, i_b[15:12]};
  assign w_blk3_c1 = {1'b0, i_a[15:12]} + {1'b0, i_b[15:12]} + 5'd1;

  assign w_c3  = w_blk0[3];
  assign w_c6  = w_c3 ? w_blk1_c1[3] : w_blk1_c0[3];
  assign w_c12 = w_c6 ? w_blk2_c1[6] : w_blk2_c0[6];

  assign o_sum[2:0]   = w_blk0[2:0];
  assign o_sum[5:3]   = w_c3  ? w_blk1_c1[2:0] : w_blk1_c0[2:0];
  assign o_sum[11:6]  = w_c6  ? w_blk2_c1[5:0] : w_blk2_c0[5:0];
  assign o_sum[15:12] = w_c12 ? w_blk3_c1[3:0] : w_blk3_c0[3:0];
  assign o_cout       = w_c12 ? w_blk3_c1[4]   : w_blk3_c0[4];

endmodule

// File: rtl/seq_shift_add_multiplier_16bit.sv
// Iterative unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier built
// around the 16-bit carry-select adder (adder width must equal 2*WIDTH).
// Each step takes SETTLE_CYCLES+1 cycles so the adder output settles
// before it is captured.
//   clk, rst_n             : clock (rising edge), async active-low reset
//   in_valid/in_ready      : operand handshake; in_a multiplicand, in_b multiplier
//   out_valid/out_ready    : product handshake; out_product = in_a*in_b
//   busy                   : high in RUN or DONE
// Optional macro SEQ_MUL_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero (product unchanged, latency shortened).
module seq_shift_add_multiplier_16bit
  import seq_mul_pkg::*;
#(
  parameter int WIDTH         = MUL_WIDTH,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);

  localparam int PW     = 2 * WIDTH;
  localparam int STEP_W = cnt_width(WIDTH);
  localparam int WAIT_W = cnt_width(SETTLE_CYCLES);

  state_t            r_state;
  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [STEP_W-1:0] r_step;
  logic [WAIT_W-1:0] r_wait;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [PW-1:0]     r_out_product;

  logic [PW-1:0]     w_sum;
  logic [PW-1:0]     w_next_acc;
  logic              w_commit;
  logic              w_last;

  // Carry out is never set while running: acc < mcand at every step.
  CarrySelectAdder_16bit_3_3_6_4 u_adder (
    .i_a    (r_acc),
    .i_b    (r_mcand),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout ()
  );

  assign w_commit   = (r_wait == WAIT_W'(SETTLE_CYCLES));
  assign w_next_acc = r_mplier[0] ? w_sum : r_acc;

`ifdef SEQ_MUL_EARLY_TERM_EN
  assign w_last = (r_step == STEP_W'(WIDTH - 1)) || (r_mplier[WIDTH-1:1] == '0);
`else
  assign w_last = (r_step == STEP_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_acc         <= '0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_step        <= '0;
      r_wait        <= '0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_mcand    <= {{WIDTH{1'b0}}, in_a};
            r_mplier   <= in_b;
            r_acc      <= '0;
            r_step     <= '0;
            r_wait     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end

        RUN: begin
          if (w_commit) begin
            r_acc    <= w_next_acc;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_step   <= r_step + 1'b1;
            r_wait   <= '0;
            if (w_last) begin
              r_state       <= DONE;
              r_out_valid   <= 1'b1;
              r_out_product <= w_next_acc;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_product = r_out_product;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_seq_shift_add_multiplier_16bit.sv
// Self-checking bench for seq_shift_add_multiplier_16bit (default parameters).
// Products are pushed to a scoreboard queue on the accept edge and popped
// by a monitor on each output handshake. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_seq_shift_add_multiplier_16bit;

  localparam int W = 8;
  localparam int S = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_a = '0;
  logic [W-1:0]    in_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*W-1:0]  out_product;
  logic            busy;

  int              n_checks = 0;
  int              n_errors = 0;
  int              n_recv   = 0;
  logic [2*W-1:0]  exp_q[$];
  logic [2*W-1:0]  exp_v;
  bit              cout_chk   = 1'b0;
  bit              rand_ready = 1'b0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier_16bit #(
    .WIDTH         (W),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy)
  );

  // Scoreboard monitor and adder carry-out watch.
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      n_recv++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL product_unexpected: got %0d with nothing outstanding", out_product);
      end else begin
        exp_v = exp_q.pop_front();
        if (out_product !== exp_v) begin
          n_errors++;
          $display("FAIL product: got %0d expected %0d", out_product, exp_v);
        end
      end
    end
    if (cout_chk && busy === 1'b1 && out_valid === 1'b0) begin
      n_checks++;
      if (dut.u_adder.o_cout !== 1'b0) begin
        n_errors++;
        $display("FAIL adder_cout: got %b expected 0", dut.u_adder.o_cout);
      end
    end
  end

  // Randomised consumer back-pressure.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SEQ_MUL_EARLY_TERM_EN
    int n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n * (S + 1);
`else
    return W * (S + 1);
`endif
  endfunction

  // Call between posedge+1 and the next negedge; returns at accept edge + 1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 1'b0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      @(posedge clk);
      exp_q.push_back((2*W)'(a) * (2*W)'(b));
      #1 in_valid = 1'b0;
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: in_ready=%b expected 1 within 2000 cycles", in_ready);
      in_valid = 1'b0;
    end
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      if (out_valid === 1'b1) return;
      @(posedge clk);
      lat++;
    end
    n_checks++;
    n_errors++;
    $display("FAIL out_valid_timeout: out_valid=%b expected 1 within 300 cycles", out_valid);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, in_ready, out_product} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%b busy=%b in_ready=%b product=%0d expected all 0",
               out_valid, busy, in_ready, out_product);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    cout_chk = 1'b1;
    send(8'd14, 8'd3);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_run_flags: busy=%b in_ready=%b expected 1/0", busy, in_ready);
    end
    @(posedge clk);
    wait_out(lat);
    lat = lat + 1;
    n_checks++;
    if (lat != exp_lat(8'd3)) begin
      n_errors++;
      $display("FAIL basic_latency: got %0d expected %0d", lat, exp_lat(8'd3));
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_valid_pulse: out_valid=%b expected 0 one cycle later", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_op_latency(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    send(a, b);
    wait_out(lat);
    n_checks++;
    if (lat != exp_lat(b)) begin
      n_errors++;
      $display("FAIL latency_%0dx%0d: got %0d expected %0d", a, b, lat, exp_lat(b));
    end
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_hold();
    int lat;
    out_ready = 1'b0;
    send(8'd15, 8'd15);
    in_a = 8'd1;
    in_b = 8'd1;
    in_valid = 1'b1;
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_product !== 16'd225 || in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_cycle%0d: valid=%b product=%0d in_ready=%b expected 1/225/0",
                 i, out_valid, out_product, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_release: valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    out_ready = 1'b1;
    send(8'd9, 8'd9);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if ({out_valid, busy, in_ready, out_product} !== '0) begin
      n_errors++;
      $display("FAIL midrun_reset: valid=%b busy=%b in_ready=%b product=%0d expected all 0",
               out_valid, busy, in_ready, out_product);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midrun_release: in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    send(8'd2, 8'd3);
    wait_out(lat);
    n_checks++;
    if (lat != exp_lat(8'd3)) begin
      n_errors++;
      $display("FAIL midrun_new_latency: got %0d expected %0d", lat, exp_lat(8'd3));
    end
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int recv0;
    int t;
    recv0 = n_recv;
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (n_recv - recv0 != 200 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_count: received %0d expected 200, outstanding %0d expected 0",
               n_recv - recv0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_op_latency(8'd255, 8'd255);
    test_op_latency(8'd5, 8'd0);
    test_op_latency(8'd7, 8'd2);
    test_op_latency(8'd0, 8'd0);
    test_op_latency(8'd200, 8'd129);
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
